// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bus of the register-file write arbiter: packed request
// lanes in, one-hot grant and the registered register-file write port out.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  // Handshake: requester k holds req[k], req_lock[k] and its addr/data lanes
  // stable until the rising edge where req[k] & gnt[k]; that edge is the transfer.
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      widx;
  logic [DW-1:0]      wdata;
  logic               we;
  logic [2:0]         owner;

  modport master (
    output req, req_lock, req_addr, req_data,
    input  gnt, widx, wdata, we, owner
  );

  modport slave (
    input  req, req_lock, req_addr, req_data,
    output gnt, widx, wdata, we, owner
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ
// requesters, with an optional bounded lock that lets one owner burst.
module regfile_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus,
  output logic                   state_dbg
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = PW + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [PW-1:0]   win;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [NREQ-1:0] gnt_c;
  logic            xfer;
  logic            found;
  logic [CW-1:0]   cand;
  logic [AW-1:0]   widx_q;
  logic [DW-1:0]   wdata_q;
  logic            we_q;

  // Grant: rotating priority search starting just after the last winner,
  // or only the owner while locked. Reset blanks every grant.
  always_comb begin
    gnt_c = '0;
    win   = owner_q;
    found = 1'b0;
    cand  = '0;
    if (!reset) begin
      if (state_q == LOCKED) begin
        gnt_c[owner_q] = bus.req[owner_q];
      end else begin
        for (int i = 1; i <= NREQ; i++) begin
          cand = {1'b0, ptr_q} + CW'(i);
          if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
          if (!found && bus.req[cand[PW-1:0]]) begin
            gnt_c[cand[PW-1:0]] = 1'b1;
            win                 = cand[PW-1:0];
            found               = 1'b1;
          end
        end
      end
    end
  end

  assign xfer = |gnt_c;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    if (xfer) begin
      if (bus.req_lock[win] && (int'(bcnt_q) + 1 < MAX_BURST)) begin
        state_d = LOCKED;
        bcnt_d  = bcnt_q + 1'b1;
      end else begin
        state_d = IDLE;
        bcnt_d  = '0;
      end
    end else if (state_q == LOCKED) begin
      // Owner walked away: give up the lock, costing one dead cycle.
      state_d = IDLE;
      bcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      bcnt_q  <= '0;
      owner_q <= '0;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      we_q    <= xfer;
      if (xfer) begin
        ptr_q   <= win;
        owner_q <= win;
        widx_q  <= bus.req_addr[int'(win)*AW +: AW];
        wdata_q <= bus.req_data[int'(win)*DW +: DW];
      end
    end
  end

  assign bus.gnt   = gnt_c;
  assign bus.widx  = widx_q;
  assign bus.wdata = wdata_q;
  assign bus.we    = we_q;
  assign bus.owner = 3'(owner_q);
  assign state_dbg = state_q;
endmodule
